// File: rtl/cpu_ctrl.sv
// Pipeline controller: stall/flush generation, interrupt detect, and commit of
// exceptions, EXRT and control-register writes from the MEM stage.
module cpu_ctrl #(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             ld_hazard,
    input  logic [IRQ_W-1:0] irq,
    input  logic [4:0]       creg_rd_addr,
    output logic [31:0]      creg_rd_data,
    input  logic [29:0]      mem_pc,
    input  logic             mem_en,
    input  logic             mem_br_flag,
    input  logic [1:0]       mem_ctrl_op,
    input  logic [4:0]       mem_dst_addr,
    input  logic [31:0]      mem_out,
    input  logic [2:0]       mem_exp_code,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic [29:0]      new_pc,
    output logic             int_detect,
    output logic             int_en
);
    localparam logic [1:0] OP_WRCR = 2'd1;
    localparam logic [1:0] OP_EXRT = 2'd2;

    localparam logic [4:0] CR_STATUS  = 5'd0;
    localparam logic [4:0] CR_MASK    = 5'd1;
    localparam logic [4:0] CR_EXPCODE = 5'd2;
    localparam logic [4:0] CR_EPC     = 5'd3;
    localparam logic [4:0] CR_EXPVEC  = 5'd4;

    logic             ie;
    logic             pie;
    logic [IRQ_W-1:0] int_mask;
    logic [3:0]       exp_code;
    logic [29:0]      epc;
    logic [29:0]      exp_vec;

    logic stall;
    logic commit;
    logic do_exp;
    logic do_exrt;
    logic do_wrcr;
    logic [31:0] mask_ext;

    assign stall   = if_busy | mem_busy;
    // Reset also gates commit so a commit in flight at reset is dropped.
    assign commit  = rst & mem_en & ~stall;
    assign do_exp  = commit & (mem_exp_code != 3'd0);
    assign do_exrt = commit & (mem_exp_code == 3'd0) & (mem_ctrl_op == OP_EXRT);
    assign do_wrcr = commit & (mem_exp_code == 3'd0) & (mem_ctrl_op == OP_WRCR);

    assign int_en = ie;

    always_comb begin
        mask_ext               = '0;
        mask_ext[IRQ_W-1:0]    = int_mask;
        creg_rd_data           = '0;
        case (creg_rd_addr)
            CR_STATUS:  creg_rd_data = {30'd0, pie, ie};
            CR_MASK:    creg_rd_data = mask_ext;
            CR_EXPCODE: creg_rd_data = {28'd0, exp_code};
            CR_EPC:     creg_rd_data = {epc, 2'b00};
            CR_EXPVEC:  creg_rd_data = {exp_vec, 2'b00};
            default:    creg_rd_data = '0;
        endcase
    end

    always_comb begin
        if_stall   = stall | ld_hazard;
        id_stall   = stall;
        ex_stall   = stall;
        mem_stall  = stall;
        if_flush   = 1'b0;
        id_flush   = ld_hazard;
        ex_flush   = 1'b0;
        mem_flush  = 1'b0;
        new_pc     = '0;
        int_detect = ie & |(irq & ~int_mask);
        if (!rst) begin
            if_stall   = 1'b0;
            id_stall   = 1'b0;
            ex_stall   = 1'b0;
            mem_stall  = 1'b0;
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            ex_flush   = 1'b1;
            mem_flush  = 1'b1;
            int_detect = 1'b0;
        end else if (do_exp || do_exrt) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            new_pc    = do_exp ? exp_vec : epc;
        end else if (do_wrcr) begin
            // WRCR retires normally in MEM; only younger stages are refetched.
            if_flush = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
            new_pc   = mem_pc + 30'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ie       <= 1'b0;
            pie      <= 1'b0;
            int_mask <= '1;
            exp_code <= '0;
            epc      <= '0;
            exp_vec  <= '0;
        end else if (do_exp) begin
            epc      <= mem_br_flag ? mem_pc - 30'd1 : mem_pc;
            exp_code <= {mem_br_flag, mem_exp_code};
            pie      <= ie;
            ie       <= 1'b0;
        end else if (do_exrt) begin
            ie <= pie;
        end else if (do_wrcr) begin
            case (mem_dst_addr)
                CR_STATUS: begin
                    ie  <= mem_out[0];
                    pie <= mem_out[1];
                end
                CR_MASK:    int_mask <= mem_out[IRQ_W-1:0];
                CR_EXPCODE: exp_code <= mem_out[3:0];
                CR_EPC:     epc      <= mem_out[31:2];
                CR_EXPVEC:  exp_vec  <= mem_out[31:2];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed-vector bench for cpu_ctrl; stimulus pushes expected outputs into a
// scoreboard queue that a negedge monitor pops and compares.
module tb_cpu_ctrl;
    localparam int IRQ_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_busy, mem_busy, ld_hazard;
    logic [IRQ_W-1:0] irq;
    logic [4:0]       creg_rd_addr;
    logic [31:0]      creg_rd_data;
    logic [29:0]      mem_pc;
    logic             mem_en, mem_br_flag;
    logic [1:0]       mem_ctrl_op;
    logic [4:0]       mem_dst_addr;
    logic [31:0]      mem_out;
    logic [2:0]       mem_exp_code;
    logic             if_stall, id_stall, ex_stall, mem_stall;
    logic             if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0]      new_pc;
    logic             int_detect, int_en;

    cpu_ctrl #(.IRQ_W(IRQ_W)) dut (
        .clk(clk), .rst(rst), .if_busy(if_busy), .mem_busy(mem_busy),
        .ld_hazard(ld_hazard), .irq(irq), .creg_rd_addr(creg_rd_addr),
        .creg_rd_data(creg_rd_data), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_out(mem_out), .mem_exp_code(mem_exp_code),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
        .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc),
        .int_detect(int_detect), .int_en(int_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  stl;   // {if, id, ex, mem}
        logic [3:0]  fl;    // {if, id, ex, mem}
        logic [29:0] npc;
        logic        intd;
        logic        ie;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.name, "stall", {28'd0, if_stall, id_stall, ex_stall, mem_stall}, {28'd0, e.stl});
            cmp(e.name, "flush", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, {28'd0, e.fl});
            cmp(e.name, "new_pc", {2'd0, new_pc}, {2'd0, e.npc});
            cmp(e.name, "int_detect", {31'd0, int_detect}, {31'd0, e.intd});
            cmp(e.name, "int_en", {31'd0, int_en}, {31'd0, e.ie});
            cmp(e.name, "creg_rd", creg_rd_data, e.rd);
        end
    end

    task automatic idle();
        if_busy = 0; mem_busy = 0; ld_hazard = 0; irq = '0; creg_rd_addr = '0;
        mem_pc = '0; mem_en = 0; mem_br_flag = 0; mem_ctrl_op = '0;
        mem_dst_addr = '0; mem_out = '0; mem_exp_code = '0;
    endtask

    task automatic wrcr(input logic [4:0] a, input logic [31:0] d, input logic [29:0] pc);
        mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = a; mem_out = d; mem_pc = pc;
    endtask

    task automatic chk(input string nm, input logic [3:0] stl, input logic [3:0] fl,
                       input logic [29:0] npc, input logic intd, input logic ie,
                       input logic [31:0] rd);
        exp_t x;
        x.name = nm; x.stl = stl; x.fl = fl; x.npc = npc;
        x.intd = intd; x.ie = ie; x.rd = rd;
        sb.push_back(x);
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        rst = 0;
        @(posedge clk); #1;

        chk("rst0", 4'b0000, 4'b1111, 30'h0, 0, 0, 32'h0);
        if_busy = 1; ld_hazard = 1; creg_rd_addr = 5'd1; irq = 8'hFF;
        wrcr(5'd4, 32'hDEADBEEC, 30'h5);
        chk("rst1", 4'b0000, 4'b1111, 30'h0, 0, 0, 32'hFF);

        rst = 1;
        idle(); creg_rd_addr = 5'd1;
        chk("post_mask", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'hFF);
        creg_rd_addr = 5'd4; irq = 8'hFF;
        chk("post_vec", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'h0);
        idle(); creg_rd_addr = 5'd3;
        chk("post_epc", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'h0);

        wrcr(5'd4, 32'h100, 30'h10); creg_rd_addr = 5'd4;
        chk("wr_vec", 4'b0000, 4'b1110, 30'h11, 0, 0, 32'h0);
        idle(); creg_rd_addr = 5'd4;
        chk("rd_vec", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'h100);

        idle(); wrcr(5'd0, 32'h1, 30'h11); irq = 8'h01;
        chk("wr_status", 4'b0000, 4'b1110, 30'h12, 0, 0, 32'h0);
        idle(); wrcr(5'd1, 32'hFE, 30'h12); irq = 8'h01;
        chk("wr_mask", 4'b0000, 4'b1110, 30'h13, 0, 1, 32'h1);
        idle(); irq = 8'h01; creg_rd_addr = 5'd1;
        chk("int_on", 4'b0000, 4'b0000, 30'h0, 1, 1, 32'hFE);
        irq = 8'h02;
        chk("int_masked", 4'b0000, 4'b0000, 30'h0, 0, 1, 32'hFE);

        idle(); irq = 8'h03; mem_en = 1; mem_ctrl_op = 2'd3; mem_pc = 30'h50;
        chk("op_rsvd", 4'b0000, 4'b0000, 30'h0, 1, 1, 32'h1);

        idle(); mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h20; mem_br_flag = 1;
        mem_ctrl_op = 2'd1; mem_dst_addr = 5'd4; mem_out = 32'h0; creg_rd_addr = 5'd4;
        chk("exc", 4'b0000, 4'b1111, 30'h40, 0, 1, 32'h100);
        idle(); creg_rd_addr = 5'd3;
        chk("exc_epc", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'h7C);
        creg_rd_addr = 5'd2;
        chk("exc_code", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'hB);
        creg_rd_addr = 5'd0;
        chk("exc_status", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'h2);
        creg_rd_addr = 5'd4;
        chk("exc_nowr", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'h100);

        idle(); mem_en = 1; mem_ctrl_op = 2'd2; mem_pc = 30'h30; mem_busy = 1;
        for (int i = 0; i < 3; i++)
            chk("exrt_stall", 4'b1111, 4'b0000, 30'h0, 0, 0, 32'h2);
        mem_busy = 0;
        chk("exrt", 4'b0000, 4'b1111, 30'h1F, 0, 0, 32'h2);
        idle(); irq = 8'h01;
        chk("exrt_ie", 4'b0000, 4'b0000, 30'h0, 1, 1, 32'h3);

        idle(); ld_hazard = 1; creg_rd_addr = 5'd1;
        chk("ld_haz", 4'b1000, 4'b0100, 30'h0, 0, 1, 32'hFE);

        idle(); if_busy = 1; mem_en = 1; mem_exp_code = 3'd5; creg_rd_addr = 5'd5;
        chk("if_busy_hold", 4'b1111, 4'b0000, 30'h0, 0, 1, 32'h0);
        idle(); wrcr(5'd7, 32'hFFFFFFFF, 30'h3FFFFFFF); creg_rd_addr = 5'd7;
        chk("wr_wrap", 4'b0000, 4'b1110, 30'h0, 0, 1, 32'h0);
        idle(); mem_en = 1; mem_exp_code = 3'd5; mem_pc = 30'h3FFFFFFF;
        chk("trap", 4'b0000, 4'b1111, 30'h40, 0, 1, 32'h3);
        idle(); creg_rd_addr = 5'd3;
        chk("trap_epc", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'hFFFFFFFC);
        creg_rd_addr = 5'd2;
        chk("trap_code", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'h5);
        creg_rd_addr = 5'd0;
        chk("trap_status", 4'b0000, 4'b0000, 30'h0, 0, 0, 32'h2);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
